// File: rtl/arm_ldm_stm_seq.sv
// Multi-cycle LDM/STM block-transfer sequencer: walks the register list lowest first,
// one word access per listed register, then optional base writeback.
module arm_ldm_stm_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [31:0]       i_inst,
  input  logic [ADDR_W-1:0] i_rn_val,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [3:0]        o_reg_rd_sel,
  input  logic [DATA_W-1:0] i_reg_rd_data,
  output logic [3:0]        o_write_rd,
  output logic              o_rd_we,
  output logic [DATA_W-1:0] o_rd_in,
  output logic              o_pc_we,
  output logic              o_rn_we,
  output logic [ADDR_W-1:0] o_rn_in
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_p, r_u, r_w, r_l;
  logic [3:0]          r_rn;
  logic [15:0]         r_list;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_rn_wb;
  logic                r_wb_en;

  logic [4:0]          w_cnt;
  logic [3:0]          w_lowest;
  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [15:0]         w_list_clr;
  logic                w_accept;
  logic                w_unused_ok;

  // Condition field, opcode class and S bit play no part in sequencing
  assign w_unused_ok = ^{i_inst[31:25], i_inst[22]};

  // List bookkeeping and start-address arithmetic
  always_comb begin
    w_cnt    = '0;
    w_lowest = '0;
    for (int i = 0; i < 16; i++) w_cnt = w_cnt + 5'(r_list[i]);
    for (int i = 15; i >= 0; i--) if (r_list[i]) w_lowest = 4'(i);
    w_off      = ADDR_W'(w_cnt) << 2;
    w_list_clr = r_list & ~(16'(1) << w_lowest);
    w_accept   = (r_state == S_XFER) && i_mem_ready;
    case ({r_p, r_u})
      2'b01:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + ADDR_W'(4);
      2'b00:   w_start_addr = r_base - w_off + ADDR_W'(4);
      default: w_start_addr = r_base - w_off;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = (w_cnt == 5'd0) ? S_WB : S_XFER;
      S_XFER:  if (w_accept && (w_list_clr == 16'd0)) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction latch, address walk and writeback precompute
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p     <= 1'b0;
      r_u     <= 1'b0;
      r_w     <= 1'b0;
      r_l     <= 1'b0;
      r_rn    <= '0;
      r_list  <= '0;
      r_base  <= '0;
      r_addr  <= '0;
      r_rn_wb <= '0;
      r_wb_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_p    <= i_inst[24];
          r_u    <= i_inst[23];
          r_w    <= i_inst[21];
          r_l    <= i_inst[20];
          r_rn   <= i_inst[19:16];
          r_list <= i_inst[15:0];
          r_base <= i_rn_val;
        end
        S_SETUP: begin
          r_addr  <= {w_start_addr[ADDR_W-1:2], 2'b00};
          r_rn_wb <= r_u ? (r_base + w_off) : (r_base - w_off);
          // A loaded base overrides writeback; an empty list never writes back
          r_wb_en <= r_w && !(r_l && r_list[r_rn]) && (w_cnt != 5'd0);
        end
        S_XFER: if (w_accept) begin
          r_list <= w_list_clr;
          r_addr <= r_addr + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_reg_rd_sel = '0;
    o_write_rd   = '0;
    o_rd_we      = 1'b0;
    o_rd_in      = '0;
    o_pc_we      = 1'b0;
    o_rn_we      = 1'b0;
    o_rn_in      = '0;
    case (r_state)
      S_SETUP: o_busy = 1'b1;
      S_XFER: begin
        o_busy       = 1'b1;
        o_mem_req    = 1'b1;
        o_mem_we     = ~r_l;
        o_mem_addr   = r_addr;
        o_reg_rd_sel = w_lowest;
        o_mem_wdata  = r_l ? '0 : i_reg_rd_data;
        if (i_mem_ready && r_l) begin
          o_write_rd = w_lowest;
          o_rd_in    = i_mem_rdata;
          o_pc_we    = (w_lowest == 4'd15);
          o_rd_we    = (w_lowest != 4'd15);
        end
      end
      S_WB: begin
        o_busy  = 1'b1;
        o_rn_we = r_wb_en;
        o_rn_in = r_rn_wb;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_ldm_stm_seq.sv
// Self-checking bench for arm_ldm_stm_seq: directed vector table, reset/abort sequence,
// and randomized instructions checked against a cycle-level transfer model.
module tb_arm_ldm_stm_seq;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_mem_ready;
  logic [31:0] i_inst, i_rn_val, i_mem_rdata, i_reg_rd_data;
  logic        o_busy, o_done, o_mem_req, o_mem_we, o_rd_we, o_pc_we, o_rn_we;
  logic [31:0] o_mem_addr, o_mem_wdata, o_rd_in, o_rn_in;
  logic [3:0]  o_reg_rd_sel, o_write_rd;

  int n_err = 0;
  int n_chk = 0;

  always #5 i_clk = ~i_clk;

  arm_ldm_stm_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_inst(i_inst), .i_rn_val(i_rn_val),
    .o_busy(o_busy), .o_done(o_done), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata), .o_reg_rd_sel(o_reg_rd_sel), .i_reg_rd_data(i_reg_rd_data),
    .o_write_rd(o_write_rd), .o_rd_we(o_rd_we), .o_rd_in(o_rd_in), .o_pc_we(o_pc_we),
    .o_rn_we(o_rn_we), .o_rn_in(o_rn_in)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] reg_val(input logic [3:0] r);
    return 32'hD000_0000 | {24'h0, r, r};
  endfunction

  // Memory and register file responders
  always_comb begin
    i_mem_rdata   = mem_val(o_mem_addr);
    i_reg_rd_data = reg_val(o_reg_rd_sel);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one instruction; mode 0 ready=1, 1 random ready, 2 three stalls on 2nd access
  task automatic run_op(input logic [31:0] inst, input logic [31:0] rn, input int mode,
                        input bit glitch, output int done_cyc, output bit saw_wb,
                        output logic [31:0] wb_val);
    logic [15:0] list;
    logic [3:0]  rnr;
    bit          p, u, w, l, exp_wb, rdy;
    int          regs[$];
    int          n, k, stall, phase, c;
    logic [31:0] a0, exp_rn, ea;
    list = inst[15:0]; rnr = inst[19:16];
    p = inst[24]; u = inst[23]; w = inst[21]; l = inst[20];
    regs = {};
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
    n = regs.size();
    case ({p, u})
      2'b01:   a0 = rn;
      2'b11:   a0 = rn + 32'd4;
      2'b00:   a0 = rn - 32'(4 * n) + 32'd4;
      default: a0 = rn - 32'(4 * n);
    endcase
    exp_wb = w && !(l && list[rnr]) && (n != 0);
    exp_rn = u ? rn + 32'(4 * n) : rn - 32'(4 * n);
    done_cyc = -1; saw_wb = 1'b0; wb_val = '0;
    k = 0; stall = 3;

    step();
    i_inst = inst; i_rn_val = rn; i_start = 1'b1; i_mem_ready = 1'b1;
    #1;
    chk("idle_busy", 32'(o_busy), 32'd0);
    step();
    i_start = 1'b0; i_inst = $urandom; i_rn_val = $urandom;
    #1;
    chk("setup_busy", 32'(o_busy), 32'd1);
    chk("setup_req", 32'(o_mem_req), 32'd0);
    phase = (n == 0) ? 1 : 0;
    c = 2;
    while (phase != 4 && c < 200) begin
      step();
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else begin
        rdy = !(k == 1 && stall > 0);
        if (k == 1 && stall > 0) stall--;
      end
      i_mem_ready = rdy;
      if (glitch && c == 3) begin
        i_start = 1'b1; i_inst = 32'hE9FF_FFFF; i_rn_val = 32'h7777_0000;
      end else i_start = 1'b0;
      #1;
      if (o_rn_we) begin saw_wb = 1'b1; wb_val = o_rn_in; end
      if (o_done && done_cyc < 0) done_cyc = c;
      case (phase)
        0: begin
          ea = (a0 + 32'(4 * k)) & ~32'd3;
          chk("xfer_req", 32'(o_mem_req), 32'd1);
          chk("xfer_done", 32'(o_done), 32'd0);
          chk("xfer_rn_we", 32'(o_rn_we), 32'd0);
          chk("xfer_addr", o_mem_addr, ea);
          chk("xfer_we", 32'(o_mem_we), 32'(!l));
          chk("xfer_sel", 32'(o_reg_rd_sel), 32'(regs[k]));
          if (!l) chk("xfer_wdata", o_mem_wdata, reg_val(4'(regs[k])));
          if (rdy && l) begin
            chk("ld_rd_we", 32'(o_rd_we), 32'(regs[k] != 15));
            chk("ld_pc_we", 32'(o_pc_we), 32'(regs[k] == 15));
            chk("ld_write_rd", 32'(o_write_rd), 32'(regs[k]));
            chk("ld_rd_in", o_rd_in, mem_val(ea));
          end else begin
            chk("no_rd_we", 32'(o_rd_we), 32'd0);
            chk("no_pc_we", 32'(o_pc_we), 32'd0);
          end
          if (rdy) begin
            k++;
            if (k == n) phase = 1;
          end
        end
        1: begin
          chk("wb_req", 32'(o_mem_req), 32'd0);
          chk("wb_busy", 32'(o_busy), 32'd1);
          chk("wb_rd_we", 32'(o_rd_we | o_pc_we), 32'd0);
          chk("wb_rn_we", 32'(o_rn_we), 32'(exp_wb));
          if (exp_wb) chk("wb_rn_in", o_rn_in, exp_rn);
          phase = 2;
        end
        2: begin
          chk("done_pulse", 32'(o_done), 32'd1);
          chk("done_busy", 32'(o_busy), 32'd1);
          chk("done_rn_we", 32'(o_rn_we), 32'd0);
          phase = 3;
        end
        default: begin
          chk("end_busy", 32'(o_busy), 32'd0);
          chk("end_done", 32'(o_done), 32'd0);
          phase = 4;
        end
      endcase
      c++;
    end
    i_start = 1'b0;
    if (phase != 4) chk("op_timeout", 32'(phase), 32'd4);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rn;
    int          mode;
    bit          glitch;
    int          exp_done;
    bit          exp_wb;
    logic [31:0] exp_rn_in;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          dc;
    bit          sw, flag;
    logic [31:0] wv, inst, lst;

    vecs[0] = '{32'hE8B0_0016, 32'h0000_1000, 0, 1'b0, 6, 1'b1, 32'h0000_100C}; // LDMIA r0!,{r1,r2,r4}
    vecs[1] = '{32'hE92D_400F, 32'h0000_2000, 0, 1'b0, 8, 1'b1, 32'h0000_1FEC}; // STMDB r13!,{r0-r3,r14}
    vecs[2] = '{32'hE890_0006, 32'h0000_1000, 2, 1'b1, 8, 1'b0, 32'h0};         // LDMIA r0,{r1,r2} stalled
    vecs[3] = '{32'hE8B2_000C, 32'h0000_0040, 0, 1'b0, 5, 1'b0, 32'h0};         // LDMIA r2!,{r2,r3}
    vecs[4] = '{32'hE990_8000, 32'hFFFF_FFFC, 0, 1'b0, 4, 1'b0, 32'h0};         // LDMIB r0,{r15}
    vecs[5] = '{32'hE8B0_0000, 32'h0000_0100, 0, 1'b1, 3, 1'b0, 32'h0};         // empty list
    vecs[6] = '{32'hE825_0081, 32'h0000_0300, 0, 1'b0, 5, 1'b1, 32'h0000_02F8}; // STMDA r5!,{r0,r7}

    i_rst = 1'b1; i_start = 1'b0; i_mem_ready = 1'b0; i_inst = '0; i_rn_val = '0;
    step(); step();
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_en", 32'({o_mem_we, o_rd_we, o_pc_we, o_rn_we}), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_rn_in", o_rn_in, 32'd0);
    i_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].inst, vecs[v].rn, vecs[v].mode, vecs[v].glitch, dc, sw, wv);
      chk($sformatf("vec%0d_done_cyc", v), 32'(dc), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_rn_we", v), 32'(sw), 32'(vecs[v].exp_wb));
      if (vecs[v].exp_wb) chk($sformatf("vec%0d_rn_in", v), wv, vecs[v].exp_rn_in);
    end

    // Reset while a transfer is in flight abandons it
    step();
    i_inst = 32'hE8B0_0016; i_rn_val = 32'h0000_1000; i_start = 1'b1; i_mem_ready = 1'b1;
    step(); i_start = 1'b0;
    step(); #1;
    chk("abort_req_before", 32'(o_mem_req), 32'd1);
    step(); i_rst = 1'b1;
    step(); #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_req", 32'(o_mem_req), 32'd0);
    chk("abort_en", 32'({o_rd_we, o_pc_we, o_rn_we, o_done}), 32'd0);
    chk("abort_addr", o_mem_addr, 32'd0);
    i_rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      flag = flag | o_busy | o_mem_req | o_rd_we | o_pc_we | o_rn_we;
    end
    chk("abort_quiet", 32'(flag), 32'd0);

    // Randomized instructions against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       lst = 32'h0;
        1:       lst = 32'h1 << $urandom_range(0, 15);
        default: lst = $urandom & 32'hFFFF;
      endcase
      inst = {4'hE, 3'b100, 5'($urandom), 4'($urandom), lst[15:0]};
      run_op(inst, $urandom, 1, 1'($urandom), dc, sw, wv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
